lsq_ptr_ctrl: RTL
=================

LSQ_PTR_CTRL -- requirements
Module: lsq_ptr_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL provide the following ports (name direction width meaning):
- alloc_valid in 1: new memory op requests an entry.
- alloc_is_store in 1: op type (1 = sw, 0 = lw).
- alloc_addr in 32: effective address of the op.
- alloc_ready out 1: entry available (equals !full).
- alloc_entry out 5: index granted this cycle (equals issue_ptr).
- commit_valid in 1: retire the head entry.
- flush in 1: squash younger entries.
- flush_ptr in 5: new issue_ptr after a squash.
- issue_ptr out 5: next entry to allocate.
- commit_ptr out 5: oldest valid entry.
- head_valid out 1: entry at commit_ptr is valid.
- head_is_store out 1: type of the head entry.
- head_addr out 32: address of the head entry.
- count out 6: number of valid entries, 0..32.
- full out 1: count == 32.
- empty out 1: count == 0.
- entry_valid out 32: per-entry valid bits.
- entry_is_store out 32: per-entry type bits.

Function
REQ-003 SHALL hold 32 entries as a ring; both pointers SHALL increment modulo 32 (31 -> 0 wrap).
REQ-004 SHALL allocate when alloc_valid && !full && !flush: on the next edge, write type and address at issue_ptr, set entry_valid[issue_ptr], and increment issue_ptr.
REQ-005 SHALL commit when commit_valid && !empty: on the next edge, clear entry_valid[commit_ptr] and increment commit_ptr.
REQ-006 SHALL ignore commit_valid when empty and alloc_valid when full; neither SHALL change state.
REQ-007 SHALL, on simultaneous legal alloc and commit, perform both and leave count unchanged.
REQ-008 SHALL evaluate full for a given cycle from the registered count at the start of that cycle, so a commit does not enable an alloc in the same cycle.
REQ-009 SHALL derive full and empty from count, never from pointer equality alone.
REQ-010 SHALL drive head_valid, head_is_store and head_addr combinationally from the entry at commit_ptr; head_addr SHALL read 0 when head_valid is 0.
REQ-011 SHALL drive all outputs from registers or from combinational reads of registered state; allocation-to-visible latency SHALL be 1 cycle.
REQ-012 SHALL hold outputs unchanged in cycles with no accepted operation.

Reset
REQ-013 SHALL clear on reset: issue_ptr, commit_ptr, count and all entry_valid/entry_is_store bits to 0; full = 0, empty = 1, alloc_ready = 1.
REQ-014 SHALL take reset priority over flush, commit and alloc in the same cycle.
REQ-015 SHALL leave stored addresses uncleared by reset; they are masked by entry_valid.

Configuration
REQ-016 SHALL gate flush support with macro LSQ_FLUSH_EN.
- Defined: flush sets issue_ptr to flush_ptr and clears entry_valid for every index from flush_ptr up to, but excluding, the old issue_ptr, modulo 32.
  - count becomes (flush_ptr - new commit_ptr) mod 32, or 32 when the queue was full and flush_ptr == issue_ptr.
  - A concurrent legal commit SHALL also take effect; a concurrent alloc SHALL be dropped.
  - flush_ptr SHALL lie in the range commit_ptr..issue_ptr (wrap-aware); other values are a caller error.
- Undefined: flush and flush_ptr SHALL be ignored and the flush logic SHALL not be synthesised.

Verification
REQ-017 SHALL cover: reset, then 3 allocs (sw 0x100, lw 0x104, lw 0x108) -> issue_ptr = 3, count = 3, entry_valid = 0x7, head_addr = 0x100, head_is_store = 1.
REQ-018 SHALL cover: 32 allocs with no commit -> full = 1, alloc_ready = 0, issue_ptr = 0; a 33rd alloc -> no change; alloc plus commit while full -> commit only, count = 31.
REQ-019 SHALL cover: commit_ptr = 30, issue_ptr = 30; alloc 4 ops -> issue_ptr = 2, entry_valid = 0xC0000003; 4 commits -> empty = 1, commit_ptr = 2.
REQ-020 SHALL cover: empty queue with simultaneous alloc and commit -> alloc only, count = 1, commit_ptr unchanged.
REQ-021 SHALL cover, with LSQ_FLUSH_EN: commit_ptr = 0, issue_ptr = 6, flush with flush_ptr = 2 -> issue_ptr = 2, count = 2, entry_valid = 0x3; without the macro -> no change.
REQ-022 SHALL cover: reset asserted in the same cycle as alloc, commit and flush -> all reset values per REQ-013.

Source files
------------

// File: rtl/lsq_ptr_ctrl.sv
// Load/store queue pointer controller: 32-entry ring with allocate, commit and optional squash.
// Optional flush support is compiled in with `define LSQ_FLUSH_EN.
module lsq_ptr_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        alloc_valid,
    input  logic        alloc_is_store,
    input  logic [31:0] alloc_addr,
    output logic        alloc_ready,
    output logic [4:0]  alloc_entry,
    input  logic        commit_valid,
    input  logic        flush,
    input  logic [4:0]  flush_ptr,
    output logic [4:0]  issue_ptr,
    output logic [4:0]  commit_ptr,
    output logic        head_valid,
    output logic        head_is_store,
    output logic [31:0] head_addr,
    output logic [5:0]  count,
    output logic        full,
    output logic        empty,
    output logic [31:0] entry_valid,
    output logic [31:0] entry_is_store
);

    logic [31:0] addr_mem [32];

    logic        flush_act;
    logic        do_alloc;
    logic        do_commit;
    logic [4:0]  issue_next;
    logic [4:0]  commit_next;
    logic [5:0]  count_next;
    logic [31:0] valid_next;
    logic [31:0] store_next;

    // Full/empty come from the registered count, so a same-cycle commit never frees a slot for alloc.
    assign full        = (count == 6'd32);
    assign empty       = (count == 6'd0);
    assign alloc_ready = !full;
    assign alloc_entry = issue_ptr;

`ifdef LSQ_FLUSH_EN
    logic [4:0]  flush_span;
    logic [4:0]  flush_offs;
    logic [31:0] flush_mask;

    assign flush_act = flush;

    // Entries from flush_ptr up to (not including) the old issue_ptr, wrap-aware.
    always_comb begin
        flush_span = issue_ptr - flush_ptr;
        flush_offs = '0;
        flush_mask = '0;
        for (int i = 0; i < 32; i++) begin
            flush_offs = 5'(i) - flush_ptr;
            if (flush_offs < flush_span) begin
                flush_mask[i] = 1'b1;
            end
        end
    end
`else
    logic unused_flush;

    assign flush_act    = 1'b0;
    assign unused_flush = ^{flush, flush_ptr};
`endif

    assign do_alloc  = alloc_valid && !full && !flush_act;
    assign do_commit = commit_valid && !empty;

    // NOTE: combinational next-state uses blocking '=' with every variable defaulted first, so no latch is inferred.
    always_comb begin
        valid_next  = entry_valid;
        store_next  = entry_is_store;
        issue_next  = issue_ptr;
        commit_next = commit_ptr;
        count_next  = count + 6'(do_alloc) - 6'(do_commit);

        if (do_commit) begin
            valid_next[commit_ptr] = 1'b0;
            commit_next            = commit_ptr + 5'd1;
        end

        if (do_alloc) begin
            valid_next[issue_ptr] = 1'b1;
            store_next[issue_ptr] = alloc_is_store;
            issue_next            = issue_ptr + 5'd1;
        end

`ifdef LSQ_FLUSH_EN
        if (flush) begin
            valid_next = valid_next & ~flush_mask;
            issue_next = flush_ptr;
            // A full queue flushed back to its own issue_ptr keeps every entry.
            if (full && (flush_ptr == issue_ptr) && !do_commit) begin
                count_next = 6'd32;
            end else begin
                count_next = {1'b0, flush_ptr - commit_next};
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_ptr      <= '0;
            commit_ptr     <= '0;
            count          <= '0;
            entry_valid    <= '0;
            entry_is_store <= '0;
        end else begin
            issue_ptr      <= issue_next;
            commit_ptr     <= commit_next;
            count          <= count_next;
            entry_valid    <= valid_next;
            entry_is_store <= store_next;
        end
    end

    // NOTE: address storage has no reset; stale addresses are masked by entry_valid.
    always_ff @(posedge clk) begin
        if (!reset && do_alloc) begin
            addr_mem[issue_ptr] <= alloc_addr;
        end
    end

    assign head_valid    = entry_valid[commit_ptr];
    assign head_is_store = head_valid & entry_is_store[commit_ptr];
    assign head_addr     = head_valid ? addr_mem[commit_ptr] : 32'd0;

endmodule
